pong_tick_gen: RTL and testbench



---
 rtl/pong_tick_gen.sv | 118 +++++++++++
 tb/tb_pong_tick_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pong_tick_gen.sv
// Multi-channel tick/strobe generator with retriggerable buzzer burst engine for Pong.
// Optional build macro TICKGEN_PAUSE_MASK_EN adds a per-channel pause_mask input.
module pong_tick_gen #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned TONE_W        = 16,
  parameter int unsigned PAD_TONE_BIT  = 15,
  parameter int unsigned WALL_TONE_BIT = 12,
  parameter int unsigned BURST_LEN     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pause,
  input  logic                    restart,
  input  logic [N_CH*CNT_W-1:0]   div,
  input  logic [N_CH-1:0]         ch_en,
`ifdef TICKGEN_PAUSE_MASK_EN
  input  logic [N_CH-1:0]         pause_mask,
`endif
  input  logic                    trig_pad,
  input  logic                    trig_wall,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         toggle,
  output logic                    buzz,
  output logic                    buzz_busy
);

  localparam int unsigned BL_W = 8;

  logic [CNT_W-1:0]  cnt_q [N_CH];
  logic [CNT_W-1:0]  cnt_d [N_CH];
  logic [N_CH-1:0]   tick_q, tick_d;
  logic [N_CH-1:0]   tog_q, tog_d;
  logic [N_CH-1:0]   frz;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic [BL_W-1:0]   burst_q, burst_d;
  logic              busy_q, busy_d;
  logic              sel_wall_q, sel_wall_d;
  logic              buzz_q, buzz_d;
  logic              trig_any;
  logic              burst_dec;
  logic              tone_bit;

`ifdef TICKGEN_PAUSE_MASK_EN
  assign frz = {N_CH{pause}} & pause_mask;
`else
  assign frz = {N_CH{pause}};
`endif

  // Per-channel divider: wrap and strobe once cnt reaches the live divisor.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      tick_d[i] = 1'b0;
      tog_d[i]  = tog_q[i];
      if (restart) begin
        cnt_d[i] = '0;
        tog_d[i] = 1'b0;
      end else if (ch_en[i] && !frz[i]) begin
        if (cnt_q[i] >= div[i*CNT_W +: CNT_W]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          tog_d[i]  = ~tog_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Tone counter, burst engine and gated buzzer; all frozen by pause.
  always_comb begin
    tone_d     = pause ? tone_q : tone_q + TONE_W'(1);
    burst_d    = burst_q;
    busy_d     = busy_q;
    sel_wall_d = sel_wall_q;
    trig_any   = (trig_pad || trig_wall) && !pause;
    burst_dec  = busy_q && tick_q[0] && ch_en[0] && !pause;
    if (trig_any) begin
      burst_d    = BL_W'(BURST_LEN);
      busy_d     = 1'b1;
      sel_wall_d = !trig_pad;
    end else if (burst_dec) begin
      burst_d = burst_q - BL_W'(1);
      busy_d  = (burst_q != BL_W'(1));
    end
    tone_bit = sel_wall_q ? tone_q[WALL_TONE_BIT] : tone_q[PAD_TONE_BIT];
    buzz_d   = busy_q && tone_bit && !pause;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      tick_q     <= '0;
      tog_q      <= '0;
      tone_q     <= '0;
      burst_q    <= '0;
      busy_q     <= 1'b0;
      sel_wall_q <= 1'b0;
      buzz_q     <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      tick_q     <= tick_d;
      tog_q      <= tog_d;
      tone_q     <= tone_d;
      burst_q    <= burst_d;
      busy_q     <= busy_d;
      sel_wall_q <= sel_wall_d;
      buzz_q     <= buzz_d;
    end
  end

  assign tick      = tick_q;
  assign toggle    = tog_q;
  assign buzz      = buzz_q;
  assign buzz_busy = busy_q;

endmodule

// File: tb/tb_pong_tick_gen.sv
// Randomized bench for pong_tick_gen against a cycle-level behavioural model.
module tb_pong_tick_gen;
  localparam int N_CH = 4, CNT_W = 8, TONE_W = 10, PAD_BIT = 9, WALL_BIT = 4, BLEN = 2;

  logic clk = 1'b0;
  logic reset, pause, restart, trig_pad, trig_wall;
  logic [N_CH*CNT_W-1:0] div;
  logic [N_CH-1:0] ch_en, pause_mask;
  logic [N_CH-1:0] tick, toggle;
  logic buzz, buzz_busy;

  int checks = 0, errors = 0;

  // model state: ages in active cycles, tick counts give toggle parity
  int  m_age [N_CH];
  int  m_nticks [N_CH];
  bit  m_tick [N_CH];
  int  m_tone, m_left;
  bit  m_busy, m_wall, m_buzz;

  always #5 clk = ~clk;

  pong_tick_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .TONE_W(TONE_W), .PAD_TONE_BIT(PAD_BIT),
                  .WALL_TONE_BIT(WALL_BIT), .BURST_LEN(BLEN)) dut (
    .clk(clk), .reset(reset), .pause(pause), .restart(restart), .div(div), .ch_en(ch_en),
`ifdef TICKGEN_PAUSE_MASK_EN
    .pause_mask(pause_mask),
`endif
    .trig_pad(trig_pad), .trig_wall(trig_wall),
    .tick(tick), .toggle(toggle), .buzz(buzz), .buzz_busy(buzz_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int divof(int i);
    return int'(div[i*CNT_W +: CNT_W]);
  endfunction

  function automatic bit frozen(int i);
`ifdef TICKGEN_PAUSE_MASK_EN
    return pause && pause_mask[i];
`else
    return pause;
`endif
  endfunction

  task automatic model_update();
    bit old_tick0, tone_hi;
    old_tick0 = m_tick[0];
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin m_age[i] = 0; m_nticks[i] = 0; m_tick[i] = 0; end
      m_tone = 0; m_left = 0; m_busy = 0; m_wall = 0; m_buzz = 0;
      return;
    end
    tone_hi = ((m_tone >> (m_wall ? WALL_BIT : PAD_BIT)) & 1) != 0;
    m_buzz  = m_busy && tone_hi && !pause;
    for (int i = 0; i < N_CH; i++) begin
      m_tick[i] = 0;
      if (restart) begin
        m_age[i] = 0; m_nticks[i] = 0;
      end else if (ch_en[i] && !frozen(i)) begin
        if (m_age[i] >= divof(i)) begin m_age[i] = 0; m_tick[i] = 1; m_nticks[i]++; end
        else m_age[i]++;
      end
    end
    if (!pause) m_tone = (m_tone + 1) % (1 << TONE_W);
    if (!pause && (trig_pad || trig_wall)) begin
      m_left = BLEN; m_busy = 1; m_wall = !trig_pad;
    end else if (m_busy && old_tick0 && ch_en[0] && !pause) begin
      m_left--; m_busy = (m_left != 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < N_CH; i++) begin
      check($sformatf("tick%0d", i), 32'(tick[i]), 32'(m_tick[i]));
      check($sformatf("toggle%0d", i), 32'(toggle[i]), 32'(m_nticks[i] % 2));
    end
    check("buzz_busy", 32'(buzz_busy), 32'(m_busy));
    check("buzz", 32'(buzz), 32'(m_buzz));
  endtask

  task automatic set_div(int i, int v);
    div[i*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  initial begin
    reset = 1; pause = 0; restart = 0; trig_pad = 0; trig_wall = 0;
    div = '0; ch_en = '1; pause_mask = '1;
    for (int i = 0; i < N_CH; i++) set_div(i, 3 + i);
    step();
    reset = 0;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_toggle", 32'(toggle), 32'd0);
    check("rst_busy", 32'(buzz_busy), 32'd0);

    // div0=3: ticks at 4,8,12 with toggle 1,0,1
    for (int k = 1; k <= 12; k++) begin
      step();
      check("dir_div3_tick", 32'(tick[0]), 32'((k % 4) == 0));
      check("dir_div3_tog", 32'(toggle[0]), 32'((k / 4) % 2));
    end

    // div0=0: strobe every cycle once the old count wraps
    set_div(0, 0);
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      check("dir_div0_tick", 32'(tick[0]), 32'd1);
    end

    // dual trigger: pad wins, busy for two tick[0] strobes
    set_div(0, 9);
    trig_pad = 1; trig_wall = 1;
    step();
    trig_pad = 0; trig_wall = 0;
    check("dir_busy_set", 32'(buzz_busy), 32'd1);
    for (int k = 0; k < 30; k++) step();
    check("dir_busy_end", 32'(buzz_busy), 32'd0);

    // randomized traffic
    for (int n = 0; n < 8000; n++) begin
      reset     = ($urandom_range(999) == 0);
      restart   = ($urandom_range(99) < 2);
      pause     = ($urandom_range(99) < 10);
      trig_pad  = ($urandom_range(99) < 3);
      trig_wall = ($urandom_range(99) < 3);
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(99) < 4) set_div(i, int'($urandom_range(12)));
        if ($urandom_range(99) < 5) ch_en[i] = ~ch_en[i];
      end
      if ($urandom_range(99) < 5) pause_mask = N_CH'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
